tlc_actuated_scheduler: RTL and testbench
=========================================

Name: tlc_actuated_scheduler

Overview:
Demand-actuated phase scheduler for a two-road intersection with a pedestrian crossing. It sequences main/side lamps from vehicle sensors and a latched pedestrian request. Main road is the rest phase; the side road and pedestrians get service on demand. All phase timing is counted in ticks of an external timebase strobe. Sits between the sensor/button synchronisers and the lamp drivers.

Parameters:
MIN_GREEN, 8, minimum green duration in ticks (either road), >=1
MAX_GREEN, 30, maximum side-road green in ticks, >=MIN_GREEN
YELLOW_T, 4, yellow duration in ticks, >=1
ALL_RED_T, 2, all-red clearance in ticks, >=1
PED_T, 6, pedestrian walk duration in ticks, >=1
CNT_W, 6, tick timer width; 2^CNT_W-1 >= every duration above

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
tick  in  1  timebase strobe, one clk cycle wide
main_sensor  in  1  vehicle present on main road (pre-synchronised)
side_sensor  in  1  vehicle present on side road (pre-synchronised)
ped_req  in  1  pedestrian button pulse/level (pre-synchronised)
main_g, main_y, main_r  out  1 each  main road lamps
side_g, side_y, side_r  out  1 each  side road lamps
ped_walk  out  1  walk signal
ped_pending  out  1  latched pedestrian request
phase  out  3  current state encoding

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- States (phase value): MAIN_G=0, MAIN_Y=1, AR_M2S=2, SIDE_G=3, SIDE_Y=4, AR_S2M=5, PED=6; 7 is illegal and recovers to MAIN_G on the next edge.
- Reset: state MAIN_G, timer 0, ped_pending 0; main_g=1, side_r=1, all other lamps 0, ped_walk 0, phase=0. Reset overrides tick and all inputs; mid-operation reset returns to these values on the next edge.
- Timer: cleared on every state change. On a tick that does not transition, timer <= timer+1, saturating at 2^CNT_W-1. No tick means no timer change and no transition. "elapsed" = timer+1 evaluated on a tick cycle.
- Transitions, evaluated only on tick cycles:
  - MAIN_G -> MAIN_Y when elapsed>=MIN_GREEN and (side_sensor or ped_pending). Otherwise main rests indefinitely. main_sensor has no effect on transitions; it is status only.
  - MAIN_Y -> AR_M2S when elapsed==YELLOW_T.
  - AR_M2S -> PED if ped_pending, else SIDE_G, when elapsed==ALL_RED_T.
  - SIDE_G -> SIDE_Y when elapsed>=MIN_GREEN and (!side_sensor or elapsed>=MAX_GREEN).
  - SIDE_Y -> AR_S2M when elapsed==YELLOW_T.
  - AR_S2M -> PED if ped_pending, else MAIN_G, when elapsed==ALL_RED_T.
  - PED -> SIDE_G if side_sensor, else MAIN_G, when elapsed==PED_T.
- ped_pending: set on any cycle with ped_req=1 while the state is not PED. Cleared on the edge that enters PED; the clear wins over a simultaneous ped_req. ped_req is ignored while in PED.
- Outputs are registered and update on the same edge as the state (zero extra latency). Lamp mapping:
  - MAIN_G: main_g, side_r
  - MAIN_Y: main_y, side_r
  - SIDE_G: main_r, side_g
  - SIDE_Y: main_r, side_y
  - AR_*: main_r, side_r
  - PED: main_r, side_r, ped_walk
- Invariants: exactly one lamp per road is on every cycle; main and side are never both non-red; ped_walk=1 implies both reds.

Decomposition:
- Shared package tlc_pkg holds the state encoding localparams (phase values 0-6) and the lamp-vector constants per state. The package is reused by the lamp driver and by bench checkers.
- One natural sub-module, tlc_tick_timer: a CNT_W-bit saturating counter with clear and tick-enable inputs, exposing elapsed.

Test Plan:
1. rst high 3 cycles, then tick every cycle for 50 cycles with no sensors or ped_req -> phase=0, main_g=1 and side_r=1 throughout.
2. side_sensor held 1 from tick 1, tick every cycle -> MAIN_G 8 ticks, MAIN_Y 4, AR_M2S 2, SIDE_G exactly 30 ticks (max-out), SIDE_Y 4, AR_S2M 2; then MAIN_G 8 and the cycle repeats.
3. side_sensor high for 3 ticks then low -> SIDE_G lasts exactly 8 ticks (min green), then SIDE_Y 4, AR_S2M 2, MAIN_G.
4. One-cycle ped_req at tick 2, no sensors -> ped_pending=1 next edge; MAIN_Y at tick 8, AR 2, PED with ped_walk=1 for 6 ticks; ped_pending=0 on PED entry; then MAIN_G.
5. side_sensor=1 with tick held 0 for 100 cycles -> no state or output change. ped_req asserted on the same edge PED is entered -> ped_pending stays 0.
6. rst pulse during SIDE_G at elapsed 5 -> next edge phase=0, main_g=1, side_r=1, ped_walk=0, ped_pending=0, timer 0.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the actuated traffic-light scheduler.
// Holds the phase encoding (the values driven on the phase output) and
// the lamp pattern for each phase, so the lamp driver and any checker
// agree on one mapping.
package tlc_pkg;

    // Phase encoding; value 7 is never entered and recovers to MAIN_G.
    typedef enum logic [2:0] {
        ST_MAIN_G = 3'd0,
        ST_MAIN_Y = 3'd1,
        ST_AR_M2S = 3'd2,
        ST_SIDE_G = 3'd3,
        ST_SIDE_Y = 3'd4,
        ST_AR_S2M = 3'd5,
        ST_PED    = 3'd6,
        ST_BAD    = 3'd7
    } tlc_state_e;

    // Lamp vector, one bit per physical output.
    typedef struct packed {
        logic main_g;
        logic main_y;
        logic main_r;
        logic side_g;
        logic side_y;
        logic side_r;
        logic ped_walk;
    } tlc_lamps_t;

    //                                          mg my mr sg sy sr pw
    localparam tlc_lamps_t LAMPS_MAIN_G  = 7'b1__0__0__0__0__1__0;
    localparam tlc_lamps_t LAMPS_MAIN_Y  = 7'b0__1__0__0__0__1__0;
    localparam tlc_lamps_t LAMPS_SIDE_G  = 7'b0__0__1__1__0__0__0;
    localparam tlc_lamps_t LAMPS_SIDE_Y  = 7'b0__0__1__0__1__0__0;
    localparam tlc_lamps_t LAMPS_ALL_RED = 7'b0__0__1__0__0__1__0;
    localparam tlc_lamps_t LAMPS_PED     = 7'b0__0__1__0__0__1__1;

    // Lamp pattern for a phase; an illegal phase shows all-red.
    function automatic tlc_lamps_t lamps_for(input tlc_state_e st);
        tlc_lamps_t l;
        case (st)
            ST_MAIN_G: l = LAMPS_MAIN_G;
            ST_MAIN_Y: l = LAMPS_MAIN_Y;
            ST_AR_M2S: l = LAMPS_ALL_RED;
            ST_SIDE_G: l = LAMPS_SIDE_G;
            ST_SIDE_Y: l = LAMPS_SIDE_Y;
            ST_AR_S2M: l = LAMPS_ALL_RED;
            ST_PED:    l = LAMPS_PED;
            default:   l = LAMPS_ALL_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_tick_timer.sv
// Saturating phase timer counted in timebase ticks.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the count (phase change); wins over tick
//   tick      - advance the count by one, saturating at all-ones
//   elapsed   - count+1, one bit wider so it never wraps; this is the
//               number of ticks the phase will have lasted if the
//               current tick is counted
module tlc_tick_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    output logic [CNT_W:0]   elapsed
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;

    // Tick counter with clear priority and saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (tick && (count_r != CNT_MAX)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign elapsed = {1'b0, count_r} + {{CNT_W{1'b0}}, 1'b1};

endmodule

// File: rtl/tlc_actuated_scheduler.sv
// Demand-actuated phase scheduler for a main/side intersection with a
// pedestrian crossing. Main green is the rest phase; side road and
// pedestrians are served on demand. All durations are in ticks.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   tick                  - one-cycle timebase strobe
//   main_sensor           - main-road presence (status only)
//   side_sensor           - side-road presence
//   ped_req               - pedestrian button
//   main_g/y/r, side_g/y/r, ped_walk - registered lamp drives
//   ped_pending           - latched pedestrian request
//   phase                 - current phase encoding
module tlc_actuated_scheduler
    import tlc_pkg::*;
#(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW_T  = 4,
    parameter int ALL_RED_T = 2,
    parameter int PED_T     = 6,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       main_sensor,
    input  logic       side_sensor,
    input  logic       ped_req,
    output logic       main_g,
    output logic       main_y,
    output logic       main_r,
    output logic       side_g,
    output logic       side_y,
    output logic       side_r,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [CNT_W:0] MIN_GREEN_C = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] MAX_GREEN_C = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0] YELLOW_C    = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0] ALL_RED_C   = (CNT_W+1)'(ALL_RED_T);
    localparam logic [CNT_W:0] PED_C       = (CNT_W+1)'(PED_T);

    tlc_state_e     state_r;
    tlc_state_e     next_state_s;
    tlc_lamps_t     lamps_r;
    logic           ped_pending_r;
    logic           state_change_s;
    logic           ped_entry_s;
    logic [CNT_W:0] elapsed_s;

    // main_sensor is reported upstream for status but never steers phases.
    logic main_sensor_unused_s;
    assign main_sensor_unused_s = main_sensor;

    assign state_change_s = (next_state_s != state_r);
    assign ped_entry_s    = (next_state_s == ST_PED) && (state_r != ST_PED);

    tlc_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_change_s),
        .tick    (tick),
        .elapsed (elapsed_s)
    );

    // Next-phase decision; only tick cycles can move the phase, except
    // that an illegal encoding falls back to main green immediately.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_MAIN_G: begin
                if (tick && (elapsed_s >= MIN_GREEN_C) && (side_sensor || ped_pending_r))
                    next_state_s = ST_MAIN_Y;
                else
                    next_state_s = ST_MAIN_G;
            end
            ST_MAIN_Y: begin
                if (tick && (elapsed_s == YELLOW_C))
                    next_state_s = ST_AR_M2S;
                else
                    next_state_s = ST_MAIN_Y;
            end
            ST_AR_M2S: begin
                if (tick && (elapsed_s == ALL_RED_C))
                    next_state_s = ped_pending_r ? ST_PED : ST_SIDE_G;
                else
                    next_state_s = ST_AR_M2S;
            end
            ST_SIDE_G: begin
                // Gap-out when the side road empties, max-out regardless.
                if (tick && (elapsed_s >= MIN_GREEN_C) &&
                    (!side_sensor || (elapsed_s >= MAX_GREEN_C)))
                    next_state_s = ST_SIDE_Y;
                else
                    next_state_s = ST_SIDE_G;
            end
            ST_SIDE_Y: begin
                if (tick && (elapsed_s == YELLOW_C))
                    next_state_s = ST_AR_S2M;
                else
                    next_state_s = ST_SIDE_Y;
            end
            ST_AR_S2M: begin
                if (tick && (elapsed_s == ALL_RED_C))
                    next_state_s = ped_pending_r ? ST_PED : ST_MAIN_G;
                else
                    next_state_s = ST_AR_S2M;
            end
            ST_PED: begin
                if (tick && (elapsed_s == PED_C))
                    next_state_s = side_sensor ? ST_SIDE_G : ST_MAIN_G;
                else
                    next_state_s = ST_PED;
            end
            default: begin
                next_state_s = ST_MAIN_G;
            end
        endcase
    end

    // Phase register and lamp register, updated on the same edge so the
    // lamps never lag the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_MAIN_G;
            lamps_r <= LAMPS_MAIN_G;
        end else begin
            state_r <= next_state_s;
            lamps_r <= lamps_for(next_state_s);
        end
    end

    // Pedestrian request latch; the clear on PED entry beats a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending_r <= 1'b0;
        end else if (ped_entry_s) begin
            ped_pending_r <= 1'b0;
        end else if (ped_req && (state_r != ST_PED)) begin
            ped_pending_r <= 1'b1;
        end else begin
            ped_pending_r <= ped_pending_r;
        end
    end

    assign main_g      = lamps_r.main_g;
    assign main_y      = lamps_r.main_y;
    assign main_r      = lamps_r.main_r;
    assign side_g      = lamps_r.side_g;
    assign side_y      = lamps_r.side_y;
    assign side_r      = lamps_r.side_r;
    assign ped_walk    = lamps_r.ped_walk;
    assign ped_pending = ped_pending_r;
    assign phase       = state_r;

endmodule

// File: tb/tb_tlc_actuated_scheduler.sv
// Self-checking bench for tlc_actuated_scheduler: a phase/dwell model
// checked every cycle, directed scenarios with hand-computed phase
// checkpoints, then randomized traffic.
module tb_tlc_actuated_scheduler;

    localparam int MIN_G = 8;
    localparam int MAX_G = 30;
    localparam int YEL   = 4;
    localparam int AR    = 2;
    localparam int PEDT  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       main_sensor = 1'b0;
    logic       side_sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic       main_g, main_y, main_r, side_g, side_y, side_r;
    logic       ped_walk, ped_pending;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    // model state: phase number, ticks already spent in it, request latch
    int m_phase = 0;
    int m_dwell = 0;
    bit m_pend  = 1'b0;
    bit armed   = 1'b0;
    int m_next;

    tlc_actuated_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .main_sensor (main_sensor),
        .side_sensor (side_sensor),
        .ped_req     (ped_req),
        .main_g      (main_g),
        .main_y      (main_y),
        .main_r      (main_r),
        .side_g      (side_g),
        .side_y      (side_y),
        .side_r      (side_r),
        .ped_walk    (ped_walk),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    // Phase rules written from the phase-by-phase service description.
    function automatic int model_next(input int ph, input int el, input bit ss,
                                      input bit pp, input bit t);
        if (!t) return ph;
        case (ph)
            0: return (el >= MIN_G && (ss || pp)) ? 1 : 0;
            1: return (el == YEL) ? 2 : 1;
            2: return (el == AR) ? (pp ? 6 : 3) : 2;
            3: return (el >= MIN_G && (!ss || el >= MAX_G)) ? 4 : 3;
            4: return (el == YEL) ? 5 : 4;
            5: return (el == AR) ? (pp ? 6 : 0) : 5;
            6: return (el == PEDT) ? (ss ? 3 : 0) : 6;
            default: return 0;
        endcase
    endfunction

    always_comb m_next = model_next(m_phase, m_dwell + 1, side_sensor, m_pend, tick);

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_dwell <= 0;
            m_pend  <= 1'b0;
            armed   <= 1'b1;
        end else begin
            m_phase <= m_next;
            if (m_next != m_phase) m_dwell <= 0;
            else if (tick)         m_dwell <= (m_dwell >= 63) ? 63 : m_dwell + 1;
            if (m_next == 6 && m_phase != 6)    m_pend <= 1'b0;
            else if (ped_req && m_phase != 6)   m_pend <= 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model plus lamp invariants.
    always @(posedge clk) begin
        #1;
        if (armed) begin
            check("phase", int'(phase), m_phase);
            check("ped_pending", int'(ped_pending), int'(m_pend));
            check("main_g", int'(main_g), int'(m_phase == 0));
            check("main_y", int'(main_y), int'(m_phase == 1));
            check("main_r", int'(main_r), int'(m_phase >= 2));
            check("side_g", int'(side_g), int'(m_phase == 3));
            check("side_y", int'(side_y), int'(m_phase == 4));
            check("side_r", int'(side_r), int'(m_phase != 3 && m_phase != 4));
            check("ped_walk", int'(ped_walk), int'(m_phase == 6));
            check("main_onehot", int'(main_g) + int'(main_y) + int'(main_r), 1);
            check("side_onehot", int'(side_g) + int'(side_y) + int'(side_r), 1);
            check("not_both_go", int'(!main_r && !side_r), 0);
            check("walk_reds", int'(ped_walk && !(main_r && side_r)), 0);
        end
    end

    // One clock: set inputs at the falling edge, return just after rising.
    task automatic cyc(input bit t, input bit ss, input bit pr, input bit r);
        @(negedge clk);
        tick        = t;
        side_sensor = ss;
        ped_req     = pr;
        rst         = r;
        main_sensor = 1'($urandom_range(0, 1));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_phase", int'(phase), 0);
        check("rst_lamps", int'({main_g, side_r, ped_walk, ped_pending}), 4'b1100);
    endtask

    initial begin
        // 1: idle rest on main green
        do_reset();
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_rest_phase", int'(phase), 0);
        check("t1_rest_lamps", int'({main_g, side_r}), 2'b11);

        // 2: continuous side demand, side green maxes out at 30
        do_reset();
        for (int k = 1; k <= 58; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (k == 7)  check("t2_k7",  int'(phase), 0);
            if (k == 8)  check("t2_k8",  int'(phase), 1);
            if (k == 12) check("t2_k12", int'(phase), 2);
            if (k == 14) check("t2_k14", int'(phase), 3);
            if (k == 43) check("t2_k43", int'(phase), 3);
            if (k == 44) check("t2_k44", int'(phase), 4);
            if (k == 48) check("t2_k48", int'(phase), 5);
            if (k == 50) check("t2_k50", int'(phase), 0);
            if (k == 58) check("t2_k58", int'(phase), 1);
        end

        // 3: side demand drops 3 ticks into side green -> min green 8
        do_reset();
        for (int k = 1; k <= 28; k++) begin
            cyc(1'b1, (k <= 17) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (k == 21) check("t3_k21", int'(phase), 3);
            if (k == 22) check("t3_k22", int'(phase), 4);
            if (k == 26) check("t3_k26", int'(phase), 5);
            if (k == 28) check("t3_k28", int'(phase), 0);
        end

        // 4: pedestrian pulse at tick 2, second press on the PED-entry edge
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, 1'b0, (k == 2 || k == 14) ? 1'b1 : 1'b0, 1'b0);
            if (k == 2)  check("t4_pend_set", int'(ped_pending), 1);
            if (k == 7)  check("t4_k7", int'(phase), 0);
            if (k == 8)  check("t4_k8", int'(phase), 1);
            if (k == 14) check("t4_ped_entry", int'({phase, ped_walk, ped_pending}), 5'b110_1_0);
            if (k == 19) check("t4_k19", int'(phase), 6);
            if (k == 20) check("t4_k20", int'({phase, ped_walk}), 4'b000_0);
        end

        // 5: no tick means no movement, even with side demand
        for (int k = 0; k < 100; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_frozen", int'({phase, main_g}), 4'b000_1);

        // 6: reset in side green at elapsed 5, then a full-length main green
        do_reset();
        for (int k = 1; k <= 18; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_in_side", int'(phase), 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("t6_rst", int'({phase, main_g, side_r, ped_walk, ped_pending}), 7'b000_1_1_0_0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (k == 7) check("t6_k7", int'(phase), 0);
            if (k == 8) check("t6_k8", int'(phase), 1);
        end

        // randomized traffic
        begin
            bit ss;
            ss = 1'b0;
            for (int k = 0; k < 4000; k++) begin
                if ($urandom_range(0, 19) == 0) ss = ~ss;
                cyc(1'($urandom_range(0, 1)), ss,
                    ($urandom_range(0, 23) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
